spi_coeff_master: RTL and testbench

SPI_COEFF_MASTER -- requirements
Module: spi_coeff_master

---
 rtl/spi_coeff_master.sv | 174 +++++++++++++++++
 tb/tb_spi_coeff_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_coeff_master.sv
// ============================================================================
// Module      : spi_coeff_master
// Description : SPI mode-0 master that streams a frame of NTaps two's
//               complement coefficients, MSB first, to a slave device.
//               Coefficients are pulled one at a time through a
//               valid/ready handshake. Every output is a flop, so spiClk,
//               cs and mosi cannot glitch.
// Ports       : clk        - system clock, rising edge
//               resetN     - asynchronous active-low reset
//               start      - one-cycle request to begin a frame
//               coeffData  - next coefficient (CoeffWidth bits)
//               coeffValid - coeffData valid
//               coeffReady - master accepts coeffData this cycle
//               spiClk     - SPI serial clock (idle low)
//               mosi       - SPI serial data
//               cs         - SPI chip select, active low
//               busy       - frame in progress
//               done       - one-cycle pulse at frame end
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_coeff_master #(
  parameter int NTaps      = 9,
  parameter int CoeffWidth = 16,
  parameter int ClkDiv     = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [CoeffWidth-1:0] coeffData,
  input  logic                  coeffValid,
  output logic                  coeffReady,
  output logic                  spiClk,
  output logic                  mosi,
  output logic                  cs,
  output logic                  busy,
  output logic                  done
);

  // The divider counts one full spiClk period (low phase then high phase).
  localparam int C_DIV_W = (2 * ClkDiv > 1) ? $clog2(2 * ClkDiv) : 1;
  localparam int C_BIT_W = $clog2(CoeffWidth);
  localparam int C_TAP_W = (NTaps > 1) ? $clog2(NTaps) : 1;

  localparam logic [C_DIV_W-1:0] C_HALF_LAST = C_DIV_W'(ClkDiv - 1);
  localparam logic [C_DIV_W-1:0] C_DIV_LAST  = C_DIV_W'(2 * ClkDiv - 1);
  localparam logic [C_BIT_W-1:0] C_BIT_LAST  = C_BIT_W'(CoeffWidth - 1);
  localparam logic [C_TAP_W-1:0] C_TAP_LAST  = C_TAP_W'(NTaps - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FETCH = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [C_DIV_W-1:0]  r_div_cnt;
  logic [C_BIT_W-1:0]  r_bit_cnt;
  logic [C_TAP_W-1:0]  r_tap_cnt;
  // Only the bits still to be sent after the one currently on mosi are kept;
  // the MSB of a newly accepted coefficient goes straight to the mosi flop.
  logic [CoeffWidth-2:0] r_shreg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tap_cnt  <= '0;
      r_shreg    <= '0;
      coeffReady <= 1'b0;
      spiClk     <= 1'b0;
      mosi       <= 1'b0;
      cs         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_tap_cnt <= '0;
          if (start) begin
            r_state <= S_SETUP;
            cs      <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_SETUP: begin
          if (r_div_cnt == C_HALF_LAST) begin
            r_div_cnt  <= '0;
            r_state    <= S_FETCH;
            coeffReady <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_FETCH: begin
          // coeffReady is high throughout this state, so valid alone
          // marks the transfer cycle.
          if (coeffValid) begin
            r_shreg    <= coeffData[CoeffWidth-2:0];
            mosi       <= coeffData[CoeffWidth-1];
            coeffReady <= 1'b0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_div_cnt == C_HALF_LAST) begin
            spiClk    <= 1'b1;
            r_div_cnt <= r_div_cnt + 1'b1;
          end else if (r_div_cnt == C_DIV_LAST) begin
            // End of the high phase: spiClk falls and the next bit is
            // presented on the same edge, so mosi only moves while low.
            spiClk    <= 1'b0;
            r_div_cnt <= '0;
            if (r_bit_cnt == C_BIT_LAST) begin
              r_bit_cnt <= '0;
              if (r_tap_cnt == C_TAP_LAST) begin
                r_state <= S_HOLD;
              end else begin
                r_tap_cnt  <= r_tap_cnt + 1'b1;
                r_state    <= S_FETCH;
                coeffReady <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              mosi      <= r_shreg[CoeffWidth-2];
              r_shreg   <= r_shreg << 1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (r_div_cnt == C_HALF_LAST) begin
            r_div_cnt <= '0;
            r_tap_cnt <= '0;
            r_state   <= S_DONE;
            cs        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            mosi      <= 1'b0;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_coeff_master.sv
// ============================================================================
// Module      : tb_spi_coeff_master
// Description : Directed self-checking bench for spi_coeff_master. A default
//               instance exercises full frames, a producer stall, ignored
//               start pulses and a mid-frame reset; a minimal instance
//               (ClkDiv=1, CoeffWidth=2, NTaps=1) checks the smallest frame.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_coeff_master;

  localparam int NT = 9;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN;
  logic          start;
  logic          coeffValid;
  logic [CW-1:0] coeffData;
  logic          coeffReady, spiClk, mosi, cs, busy, done;

  logic          start2;
  logic          valid2;
  logic [1:0]    data2;
  logic          ready2, spiClk2, mosi2, cs2, busy2, done2;

  logic [CW-1:0] words [0:NT-1];
  int            idx;

  assign coeffData = (idx < NT) ? words[idx] : '0;

  spi_coeff_master #(.NTaps(NT), .CoeffWidth(CW), .ClkDiv(4)) dut (
    .clk(clk), .resetN(resetN), .start(start), .coeffData(coeffData),
    .coeffValid(coeffValid), .coeffReady(coeffReady), .spiClk(spiClk),
    .mosi(mosi), .cs(cs), .busy(busy), .done(done)
  );

  spi_coeff_master #(.NTaps(1), .CoeffWidth(2), .ClkDiv(1)) dut2 (
    .clk(clk), .resetN(resetN), .start(start2), .coeffData(data2),
    .coeffValid(valid2), .coeffReady(ready2), .spiClk(spiClk2),
    .mosi(mosi2), .cs(cs2), .busy(busy2), .done(done2)
  );

  // Slave model for the default instance: capture on spiClk rising edges.
  logic [CW-1:0] ssh = '0;
  int            sbits = 0;
  int            rises = 0;
  logic [CW-1:0] cap [$];
  always @(posedge spiClk or posedge cs) begin
    if (cs) begin
      sbits = 0;
    end else begin
      rises = rises + 1;
      ssh   = {ssh[CW-2:0], mosi};
      sbits = sbits + 1;
      if (sbits == CW) begin
        cap.push_back(ssh);
        sbits = 0;
      end
    end
  end

  // Slave model for the minimal instance.
  logic bits2 [$];
  time  rt2 [$];
  always @(posedge spiClk2) begin
    if (!cs2) begin
      bits2.push_back(mosi2);
      rt2.push_back($time);
    end
  end

  // Protocol monitor on both instances, sampled away from the active edge.
  int   viol = 0;
  logic prev_mosi = 1'b0;
  logic prev_mosi2 = 1'b0;
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (mosi !== prev_mosi && spiClk) viol = viol + 1;
      if (spiClk && cs) viol = viol + 1;
      if (coeffReady && (cs || spiClk || !busy)) viol = viol + 1;
      if (mosi2 !== prev_mosi2 && spiClk2) viol = viol + 1;
      if (spiClk2 && cs2) viol = viol + 1;
      if (ready2 && (cs2 || spiClk2 || !busy2)) viol = viol + 1;
    end
    prev_mosi  = mosi;
    prev_mosi2 = mosi2;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Runs one frame on the default instance. stall_tap >= 0 withholds
  // coeffValid for 50 FETCH cycles ahead of that coefficient index.
  task automatic run_frame(input string tag, input int stall_tap, input bit extra_start,
                           output int cs_low, output int done_at, output int stall_rdy);
    int n, stall_st, scnt, bad_cs, bad_done;
    bit xfer;
    cs_low = 0; done_at = 0; stall_rdy = 0; stall_st = 0; scnt = 0;
    idx = 0;
    coeffValid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check({tag, "_cs_fall"}, cs, 1'b0);
    while (!done && n < 3000) begin
      if (!cs) cs_low++;
      if (stall_tap >= 0) begin
        case (stall_st)
          0: if (idx == stall_tap) begin coeffValid = 1'b0; stall_st = 1; end
          1: if (coeffReady) begin stall_st = 2; scnt = 0; end
          2: begin
            scnt++;
            if (coeffReady && !spiClk && !cs) stall_rdy++;
            if (scnt == 50) begin coeffValid = 1'b1; stall_st = 3; end
          end
          default: ;
        endcase
      end
      start = extra_start && (n == 500);
      xfer  = coeffValid && coeffReady;
      @(posedge clk); #1;
      n++;
      if (xfer) idx++;
    end
    start = 1'b0;
    done_at = n;
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_cs_at_done"}, cs, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    if (extra_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bad_cs = 0; bad_done = 0;
      for (int i = 0; i < 20; i++) begin
        if (!cs) bad_cs++;
        if (done) bad_done++;
        @(posedge clk); #1;
      end
      check({tag, "_no_restart_cs"}, bad_cs, 0);
      check({tag, "_no_second_done"}, bad_done, 0);
    end
  endtask

  task automatic check_words(input string tag, input int base);
    check({tag, "_word_count"}, cap.size() - base, NT);
    for (int i = 0; i < NT; i++)
      check($sformatf("%s_word%0d", tag, i),
            (base + i < cap.size()) ? cap[base + i] : 'x, words[i]);
  endtask

  initial begin
    int cs_low, done_at, stall_rdy, base_cap, base_rise, m, low2;
    words[0] = 16'h8001; words[1] = 16'h7FFF; words[2] = 16'h1234;
    words[3] = 16'hA5A5; words[4] = 16'h0000; words[5] = 16'hFFFF;
    words[6] = 16'h5A5A; words[7] = 16'hC3C3; words[8] = 16'h0F0F;
    idx = 0;
    resetN = 1'b0; start = 1'b0; coeffValid = 1'b1;
    start2 = 1'b0; valid2 = 1'b1; data2 = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs, 1'b1);
    check("rst_spiclk", spiClk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", coeffReady, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain frame with coeffValid held high.
    base_cap = cap.size(); base_rise = rises;
    run_frame("f1", -1, 1'b0, cs_low, done_at, stall_rdy);
    check("f1_cs_low", cs_low, 1169);
    check("f1_done_at", done_at, 1170);
    check("f1_rises", rises - base_rise, NT * CW);
    check_words("f1", base_cap);
    repeat (3) @(posedge clk);
    #1;

    // Producer stalls ahead of the third coefficient.
    base_cap = cap.size(); base_rise = rises;
    run_frame("f2", 2, 1'b0, cs_low, done_at, stall_rdy);
    check("f2_cs_low", cs_low, 1219);
    check("f2_done_at", done_at, 1220);
    check("f2_stall_ready", stall_rdy, 50);
    check("f2_rises", rises - base_rise, NT * CW);
    check_words("f2", base_cap);
    repeat (3) @(posedge clk);
    #1;

    // Extra start pulses mid-SHIFT and in the DONE cycle.
    base_cap = cap.size(); base_rise = rises;
    run_frame("f3", -1, 1'b1, cs_low, done_at, stall_rdy);
    check("f3_cs_low", cs_low, 1169);
    check("f3_done_at", done_at, 1170);
    check("f3_rises", rises - base_rise, NT * CW);
    check_words("f3", base_cap);

    // Reset while bit 7 of the fifth coefficient is on the wire.
    base_cap = cap.size(); base_rise = rises;
    idx = 0; coeffValid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m = 0;
    while ((rises - base_rise) < 72 && m < 3000) begin
      bit xfer;
      xfer = coeffValid && coeffReady;
      @(posedge clk); #1;
      m++;
      if (xfer) idx++;
    end
    check("r_reached_bit7", rises - base_rise, 72);
    #2;
    resetN = 1'b0;
    #1;
    check("r_cs", cs, 1'b1);
    check("r_spiclk", spiClk, 1'b0);
    check("r_mosi", mosi, 1'b0);
    check("r_busy", busy, 1'b0);
    check("r_ready", coeffReady, 1'b0);
    check("r_words_before", cap.size() - base_cap, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
    base_cap = cap.size(); base_rise = rises;
    run_frame("f4", -1, 1'b0, cs_low, done_at, stall_rdy);
    check("f4_cs_low", cs_low, 1169);
    check("f4_done_at", done_at, 1170);
    check("f4_rises", rises - base_rise, NT * CW);
    check_words("f4", base_cap);

    // Minimal configuration: one 2-bit coefficient, ClkDiv=1.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    m = 1; low2 = 0;
    while (!done2 && m < 50) begin
      if (!cs2) low2++;
      @(posedge clk); #1;
      m++;
    end
    check("m_cs_low", low2, 7);
    check("m_done_at", m, 8);
    check("m_cs_at_done", cs2, 1'b1);
    check("m_rises", bits2.size(), 2);
    check("m_bit0", (bits2.size() > 0) ? bits2[0] : 1'bx, 1'b1);
    check("m_bit1", (bits2.size() > 1) ? bits2[1] : 1'bx, 1'b0);
    check("m_period", (rt2.size() > 1) ? 32'(rt2[1] - rt2[0]) : 32'hFFFF_FFFF, 20);

    repeat (3) @(posedge clk);
    #1;
    check("monitor_viol", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
